// File: rtl/dtc_pkg.sv
// Shared types and constants for the programmable decision-tree walker.
// Node word layout, MSB to LSB: {is_leaf, feat, hi_ptr, lo_ptr, value}.
package dtc_pkg;

    localparam int unsigned IN_W      = 7;
    localparam int unsigned OUT_W     = 10;
    localparam int unsigned NODE_AW   = 7;
    localparam int unsigned MAX_DEPTH = 8;
    localparam int unsigned DEPTH_W   = 8;

    localparam int unsigned FEAT_W = $clog2(IN_W);
    localparam int unsigned NODE_W = 1 + FEAT_W + 2 * NODE_AW + OUT_W;
    localparam int unsigned NODE_N = 1 << NODE_AW;

    // Field offsets inside a node word
    localparam int unsigned VALUE_LSB = 0;
    localparam int unsigned LO_LSB    = VALUE_LSB + OUT_W;
    localparam int unsigned HI_LSB    = LO_LSB + NODE_AW;
    localparam int unsigned FEAT_LSB  = HI_LSB + NODE_AW;
    localparam int unsigned LEAF_BIT  = FEAT_LSB + FEAT_W;

    typedef struct packed {
        logic               is_leaf;
        logic [FEAT_W-1:0]  feat;
        logic [NODE_AW-1:0] hi_ptr;
        logic [NODE_AW-1:0] lo_ptr;
        logic [OUT_W-1:0]   value;
    } node_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } state_e;

    // Build a node word for loaders and benches
    function automatic logic [NODE_W-1:0] pack_node(
        input logic               is_leaf,
        input logic [FEAT_W-1:0]  feat,
        input logic [NODE_AW-1:0] hi_ptr,
        input logic [NODE_AW-1:0] lo_ptr,
        input logic [OUT_W-1:0]   value
    );
        logic [NODE_W-1:0] w;
        w                        = '0;
        w[LEAF_BIT]              = is_leaf;
        w[FEAT_LSB +: FEAT_W]    = feat;
        w[HI_LSB +: NODE_AW]     = hi_ptr;
        w[LO_LSB +: NODE_AW]     = lo_ptr;
        w[VALUE_LSB +: OUT_W]    = value;
        return w;
    endfunction

endpackage

// File: rtl/dtc_node_ram.sv
// Node table: register array with one synchronous write port, one
// asynchronous read port and a per-node valid bit cleared by reset.
// Ports: clk, rst_n; we/waddr/wdata write port; raddr -> rdata_c, rvalid_c.
module dtc_node_ram
    import dtc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [NODE_AW-1:0] waddr,
    input  logic [NODE_W-1:0]  wdata,
    input  logic [NODE_AW-1:0] raddr,
    output logic [NODE_W-1:0]  rdata_c,
    output logic               rvalid_c
);

    logic [NODE_W-1:0] mem_q [NODE_N];
    logic [NODE_N-1:0] valid_q;
    logic [NODE_N-1:0] valid_d;

    // Storage is intentionally not reset; only the valid bits are
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (we) begin
            valid_d[waddr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign rdata_c  = mem_q[raddr];
    assign rvalid_c = valid_q[raddr];

endmodule

// File: rtl/dtc_walker.sv
// Programmable decision-tree classifier: walks a run-time loaded node table
// one level per clock and returns class code, depth and an abort flag.
// Ports: clk, rst_n; cfg_we/cfg_addr/cfg_wdata/cfg_ready node load port;
// in_valid/in_ready/in_data feature input; out_valid/out_ready/out_data/
// out_depth/out_err result.
module dtc_walker
    import dtc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [NODE_AW-1:0] cfg_addr,
    input  logic [NODE_W-1:0]  cfg_wdata,
    output logic               cfg_ready,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic [DEPTH_W-1:0] out_depth,
    output logic               out_err
);

    state_e               state_q, state_d;
    logic [IN_W-1:0]      vec_q, vec_d;
    logic [NODE_AW-1:0]   ptr_q, ptr_d;
    logic [DEPTH_W-1:0]   depth_q, depth_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [OUT_W-1:0]     out_data_q, out_data_d;
    logic [DEPTH_W-1:0]   out_depth_q, out_depth_d;
    logic                 out_err_q, out_err_d;

    logic                 ram_we_c;
    logic [NODE_W-1:0]    rdata_c;
    logic                 rvalid_c;
    node_t                node_c;

    // Writes only land while idle; in_ready_q is high exactly then
    assign ram_we_c = cfg_we & in_ready_q;

    dtc_node_ram u_ram (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (ram_we_c),
        .waddr    (cfg_addr),
        .wdata    (cfg_wdata),
        .raddr    (ptr_q),
        .rdata_c  (rdata_c),
        .rvalid_c (rvalid_c)
    );

    assign node_c = node_t'(rdata_c);

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        ptr_d       = ptr_q;
        depth_d     = depth_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_depth_d = out_depth_q;
        out_err_d   = out_err_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    vec_d      = in_data;
                    ptr_d      = '0;
                    depth_d    = '0;
                    in_ready_d = 1'b0;
                    state_d    = WALK;
                end
            end

            WALK: begin
                if (!rvalid_c || (32'(node_c.feat) >= IN_W)) begin
                    out_err_d   = 1'b1;
                    out_data_d  = '0;
                    out_depth_d = depth_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (node_c.is_leaf) begin
                    out_err_d   = 1'b0;
                    out_data_d  = node_c.value;
                    out_depth_d = depth_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (depth_q == DEPTH_W'(MAX_DEPTH)) begin
                    // Depth cap catches loops in the table
                    out_err_d   = 1'b1;
                    out_data_d  = '0;
                    out_depth_d = depth_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    ptr_d   = vec_q[node_c.feat] ? node_c.hi_ptr : node_c.lo_ptr;
                    depth_d = depth_q + DEPTH_W'(1);
                end
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            ptr_q       <= '0;
            depth_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_depth_q <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            ptr_q       <= ptr_d;
            depth_q     <= depth_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_depth_q <= out_depth_d;
            out_err_q   <= out_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign cfg_ready = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_depth = out_depth_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_dtc_walker.sv
// Bench for dtc_walker: directed and random trees checked against a
// behavioural tree-walk model held in plain arrays.
module tb_dtc_walker;
    import dtc_pkg::*;

    logic               clk       = 1'b0;
    logic               rst_n     = 1'b1;
    logic               cfg_we    = 1'b0;
    logic [NODE_AW-1:0] cfg_addr  = '0;
    logic [NODE_W-1:0]  cfg_wdata = '0;
    logic               cfg_ready;
    logic               in_valid  = 1'b0;
    logic               in_ready;
    logic [IN_W-1:0]    in_data   = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [OUT_W-1:0]   out_data;
    logic [7:0]         out_depth;
    logic               out_err;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        bit valid;
        bit leaf;
        int feat;
        int hi;
        int lo;
        int value;
    } mnode_t;

    mnode_t m [128];
    mnode_t pend;
    int     pend_addr;

    always #5 clk = ~clk;

    dtc_walker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_ready (cfg_ready),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_depth (out_depth),
        .out_err   (out_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_model;
        for (int i = 0; i < 128; i++) m[i].valid = 1'b0;
    endtask

    // Present a node on the config port without strobing it
    task automatic set_node(input int a, input bit leaf, input int feat,
                            input int hi, input int lo, input int val);
        pend_addr = a;
        pend      = '{1'b1, leaf, feat, hi, lo, val};
        cfg_addr  = 7'(a);
        cfg_wdata = pack_node(leaf, 3'(feat), 7'(hi), 7'(lo), 10'(val));
    endtask

    task automatic wr(input int a, input bit leaf, input int feat,
                      input int hi, input int lo, input int val);
        set_node(a, leaf, feat, hi, lo, val);
        cfg_we = 1'b1;
        chk("cfg_ready_idle", 32'(cfg_ready), 32'd1);
        tick;
        cfg_we      = 1'b0;
        m[pend_addr] = pend;
    endtask

    // Reference walk straight from the tree rules
    function automatic void mwalk(input int v, output int d, output int dep, output int err);
        int p;
        p = 0; d = 0; dep = 0; err = 0;
        for (int guard = 0; guard < 1000; guard++) begin
            if (!m[p].valid || m[p].feat >= int'(IN_W)) begin
                err = 1;
                return;
            end
            if (m[p].leaf) begin
                d = m[p].value;
                return;
            end
            if (dep == int'(MAX_DEPTH)) begin
                err = 1;
                return;
            end
            p = (((v >> m[p].feat) & 1) != 0) ? m[p].hi : m[p].lo;
            dep++;
        end
    endfunction

    // One full transaction; with_wr also strobes the pending node in the accept cycle
    task automatic txn(input int v, input bit with_wr);
        int ed, edep, eerr, cnt;
        if (with_wr) begin
            cfg_we       = 1'b1;
            m[pend_addr] = pend;
        end
        mwalk(v, ed, edep, eerr);
        in_data  = 7'(v);
        in_valid = 1'b1;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        chk("in_ready_busy", 32'(in_ready), 32'd0);
        cnt = 1;
        while (out_valid !== 1'b1 && cnt < 400) begin
            tick;
            cnt++;
        end
        chk("latency", 32'(cnt), 32'(edep + 2));
        chk("out_data", 32'(out_data), 32'(ed));
        chk("out_depth", 32'(out_depth), 32'(edep));
        chk("out_err", 32'(out_err), 32'(eerr));
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int cnt;

        // Power-on reset
        clear_model();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_depth", 32'(out_depth), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        // Basic two-leaf tree
        wr(0, 1'b0, 4, 2, 1, 0);
        wr(1, 1'b1, 0, 0, 0, 10'b0001111101);
        wr(2, 1'b1, 0, 0, 0, 10'b1000111111);
        txn(7'b0010000, 1'b0);
        chk("basic_hi_value", 32'(out_data), 32'(10'b1000111111));
        txn(0, 1'b0);
        chk("basic_lo_value", 32'(out_data), 32'(10'b0001111101));

        // Three-level tree on bits 4, 2, 5 with full input sweep
        wr(0, 1'b0, 4, 2, 1, 0);
        wr(1, 1'b0, 2, 4, 3, 0);
        wr(2, 1'b0, 2, 6, 5, 0);
        for (int n = 3; n <= 6; n++) wr(n, 1'b0, 5, 8 + 2 * (n - 3), 7 + 2 * (n - 3), 0);
        for (int n = 7; n <= 14; n++) wr(n, 1'b1, 0, 0, 0, int'($urandom_range(1023)));
        for (int v = 0; v < 128; v++) txn(v, 1'b0);

        // Self loop hits the depth cap
        wr(0, 1'b0, 0, 0, 0, 0);
        txn(int'($urandom_range(127)), 1'b0);

        // Hold result with out_ready low; a config write meanwhile is dropped
        wr(0, 1'b1, 0, 0, 0, 10'h155);
        in_data  = 7'h11;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        cnt = 1;
        while (out_valid !== 1'b1 && cnt < 400) begin
            tick;
            cnt++;
        end
        chk("hold_latency", 32'(cnt), 32'd2);
        set_node(0, 1'b1, 0, 0, 0, 10'h0AA);
        cfg_we = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            cfg_we = 1'b0;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'h155);
            chk("hold_depth", 32'(out_depth), 32'd0);
            chk("hold_err", 32'(out_err), 32'd0);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_cfg_ready", 32'(cfg_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        txn(3, 1'b0);

        // Write and accept in the same cycle: the walk sees the new node
        set_node(0, 1'b1, 0, 0, 0, 10'h2C3);
        txn(5, 1'b1);

        // Asynchronous reset mid-walk
        wr(0, 1'b0, 0, 0, 0, 0);
        in_data  = '0;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("midrst_out_err", 32'(out_err), 32'd0);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        txn(0, 1'b0);
        chk("noreload_err", 32'(out_err), 32'd1);

        // Unwritten child, then out-of-range feature
        wr(0, 1'b0, 0, 5, 5, 0);
        txn(1, 1'b0);
        chk("unwritten_depth", 32'(out_depth), 32'd1);
        wr(0, 1'b0, 7, 1, 1, 0);
        txn(2, 1'b0);
        chk("badfeat_depth", 32'(out_depth), 32'd0);

        // Random tables and inputs
        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < 16; a++) begin
                wr(a, ($urandom_range(9) < 4), int'($urandom_range(7)),
                   int'($urandom_range(19)), int'($urandom_range(19)),
                   int'($urandom_range(1023)));
            end
            for (int t = 0; t < 25; t++) begin
                if ($urandom_range(3) == 0) begin
                    set_node(int'($urandom_range(15)), ($urandom_range(1) == 1),
                             int'($urandom_range(6)), int'($urandom_range(15)),
                             int'($urandom_range(15)), int'($urandom_range(1023)));
                    txn(int'($urandom_range(127)), 1'b1);
                end else begin
                    txn(int'($urandom_range(127)), 1'b0);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
